// File: rtl/ub_systolic_feeder.sv
// ----------------------------------------------------------------------------
// ub_systolic_feeder
//
// Read sequencer between the unified buffer and one edge (input rows or
// weight columns) of the 2x2 systolic array. A start pulse latches a base
// address, a row count M and a transpose flag. The block then issues M reads
// per lane. Lane 2 is issued one cycle behind lane 1, so the data reaches the
// array diagonally skewed.
//
// Element (row r, lane c) lives at:
//   row-major    (transpose=0): base + 2r + c
//   column-major (transpose=1): base + c*M + r
// All address sums wrap modulo 2^ADDR_WIDTH.
//
// Timing relative to the start edge (edge 0):
//   mem_rd_en_1    cycles 1..M      mem_rd_en_2    cycles 2..M+1
//   valid_1_out    cycles 3..M+2    valid_2_out    cycles 4..M+3
//   busy_out       cycles 1..M+3    done_out       cycle  M+4
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   start_in                  one-cycle request pulse (ignored unless idle)
//   transpose_in, addr_in,
//   loc_in                    request parameters, sampled with start_in
//   mem_rd_en_x/addr_x        unified buffer read strobes and addresses
//   mem_rd_data_x             read data, valid one cycle after the strobe
//   data_x_out/valid_x_out    skewed element lanes towards the array
//   busy_out, done_out        request status
// ----------------------------------------------------------------------------
module ub_systolic_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  transpose_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [ADDR_WIDTH-1:0] loc_in,
    output logic                  mem_rd_en_1,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_1,
    output logic                  mem_rd_en_2,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_2,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_1,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_2,
    output logic [DATA_WIDTH-1:0] data_1_out,
    output logic [DATA_WIDTH-1:0] data_2_out,
    output logic                  valid_1_out,
    output logic                  valid_2_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    // Control state
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;        // ISSUE: step index 0..M, DRAIN: 0..1
    logic                  tr_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] m_q;

    // Next-cycle strobe/address values, registered onto the memory ports
    logic                  issue_1;
    logic                  issue_2;
    logic [ADDR_WIDTH-1:0] row_2;
    logic [ADDR_WIDTH-1:0] addr_1_next;
    logic [ADDR_WIDTH-1:0] addr_2_next;

    // Cycle in which the memory presents the read data for each lane
    logic                  rd_pend_1;
    logic                  rd_pend_2;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // ISSUE lasts M+1 steps: lane 1 uses steps 0..M-1, lane 2 uses 1..M.
    // DRAIN covers two cycles, for the memory return and the output register.
    // All outputs are registered one cycle behind the state, so these steps
    // appear on the ports shifted one cycle later.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            tr_q   <= 1'b0;
            base_q <= '0;
            m_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in && (loc_in != ADDR_ZERO)) begin
                        tr_q   <= transpose_in;
                        base_q <= addr_in;
                        m_q    <= loc_in;
                        cnt    <= '0;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cnt == m_q) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (cnt == ADDR_ONE) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + ADDR_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        issue_1     = 1'b0;
        issue_2     = 1'b0;
        row_2       = '0;
        addr_1_next = '0;
        addr_2_next = '0;

        if (state == S_ISSUE) begin
            issue_1 = (cnt < m_q);
            issue_2 = (cnt != ADDR_ZERO);
        end

        // Lane 2 trails lane 1 by one step.
        row_2 = cnt - ADDR_ONE;

        if (issue_1) begin
            if (tr_q) begin
                addr_1_next = base_q + cnt;
            end else begin
                addr_1_next = base_q + (cnt << 1);
            end
        end

        if (issue_2) begin
            if (tr_q) begin
                // The second column starts M elements after the first.
                addr_2_next = base_q + m_q + row_2;
            end else begin
                addr_2_next = base_q + (row_2 << 1) + ADDR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered memory strobes and status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_rd_en_1   <= 1'b0;
            mem_rd_addr_1 <= '0;
            mem_rd_en_2   <= 1'b0;
            mem_rd_addr_2 <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            mem_rd_en_1   <= issue_1;
            mem_rd_addr_1 <= addr_1_next;
            mem_rd_en_2   <= issue_2;
            mem_rd_addr_2 <= addr_2_next;
            busy_out      <= (state == S_ISSUE) || (state == S_DRAIN);
            done_out      <= (state == S_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Return pipeline: strobe -> memory data -> output register
    // ------------------------------------------------------------------------
    // NOTE: the data registers are reset along with the valids, because the
    // outputs must read as zero whenever they are not valid. Without that
    // reset, stale data could leak out after a mid-run reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend_1   <= 1'b0;
            rd_pend_2   <= 1'b0;
            valid_1_out <= 1'b0;
            valid_2_out <= 1'b0;
            data_1_out  <= '0;
            data_2_out  <= '0;
        end else begin
            rd_pend_1   <= mem_rd_en_1;
            rd_pend_2   <= mem_rd_en_2;
            valid_1_out <= rd_pend_1;
            valid_2_out <= rd_pend_2;
            data_1_out  <= rd_pend_1 ? mem_rd_data_1 : '0;
            data_2_out  <= rd_pend_2 ? mem_rd_data_2 : '0;
        end
    end

endmodule
